// File: rtl/booth_mul_pkg.sv
// Shared constants, FSM state type and limb-select helper for the Booth multiply sequencer.
package booth_mul_pkg;

  localparam int A_W     = 256;
  localparam int LIMB_W  = 64;
  localparam int N_LIMBS = 4;
  localparam int B_W     = LIMB_W * N_LIMBS;
  localparam int P_W     = A_W + LIMB_W;
  localparam int RES_W   = A_W + LIMB_W * N_LIMBS;
  localparam int CNT_W   = $clog2(N_LIMBS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [LIMB_W-1:0] limb_of(input logic [B_W-1:0] b, input int idx);
    return b[LIMB_W*idx +: LIMB_W];
  endfunction

endpackage

// File: rtl/booth_mul_seq_ctrl_if.sv
// Operand/result handshake bundle between the bignum datapath and the multiply sequencer.
interface booth_mul_seq_ctrl_if;
  import booth_mul_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   in_a;
  logic [B_W-1:0]   in_b;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_p;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p
  );

endinterface

// File: rtl/booth_mul_acc.sv
// 512-bit shift-add accumulator: adds a partial product at a limb offset, with synchronous clear.
// Latency: acc_nxt is combinational from acc and p; acc updates on the clock edge. No backpressure.
module booth_mul_acc
  import booth_mul_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             add,
  input  logic [CNT_W-1:0] cnt,
  input  logic [P_W-1:0]   p,
  output logic [RES_W-1:0] acc_nxt
);

  logic [RES_W-1:0] acc_q;
  logic [RES_W-1:0] p_ext;

  assign p_ext   = {{(RES_W-P_W){1'b0}}, p};
  // Exact product fits in RES_W, so the truncating add never drops a carry.
  assign acc_nxt = acc_q + (p_ext << (LIMB_W * int'(cnt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (add) begin
      acc_q <= acc_nxt;
    end
  end

endmodule

// File: rtl/booth_mul_seq_ctrl.sv
// 256x256 unsigned multiply by stepping a shared 256x64 booth_top over four B limbs (macro MUL_PIPE_REG_EN).
// Latency: N_LIMBS+1 cycles accept-to-out_valid (2*N_LIMBS+1 with MUL_PIPE_REG_EN).
// Backpressure: in_ready low while busy; result held in DONE until out_ready.
module booth_mul_seq_ctrl
  import booth_mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  booth_mul_seq_ctrl_if.slave io,
  output logic [A_W-1:0]    mul_a,
  output logic [LIMB_W-1:0] mul_b,
  input  logic [P_W-1:0]    mul_p,
  output logic              busy
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [B_W-1:0]   b_q;
  logic             acc_clr;
  logic             acc_add;
  logic [P_W-1:0]   acc_p;
  logic [RES_W-1:0] acc_nxt;

  assign acc_clr = (state == IDLE) && io.in_valid && io.in_ready;

`ifdef MUL_PIPE_REG_EN
  // ph=0 drives the limb into booth_top, ph=1 accumulates the registered product.
  logic           ph;
  logic [P_W-1:0] p_q;

  assign acc_add = (state == RUN) && ph;
  assign acc_p   = p_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ph  <= 1'b0;
      p_q <= '0;
    end else if (state == RUN) begin
      ph <= ~ph;
      if (!ph) p_q <= mul_p;
    end else begin
      ph <= 1'b0;
    end
  end
`else
  assign acc_add = (state == RUN);
  assign acc_p   = mul_p;
`endif

  booth_mul_acc u_acc (
    .clk     (clk),
    .rst     (rst),
    .clr     (acc_clr),
    .add     (acc_add),
    .cnt     (cnt),
    .p       (acc_p),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      io.in_ready  <= 1'b1;
      io.out_valid <= 1'b0;
      io.out_p     <= '0;
      busy         <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      cnt          <= '0;
      b_q          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            mul_a       <= io.in_a;
            mul_b       <= io.in_b[LIMB_W-1:0];
            b_q         <= io.in_b;
            cnt         <= '0;
            io.in_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          if (acc_add) begin
            if (cnt == CNT_W'(N_LIMBS - 1)) begin
              io.out_p     <= acc_nxt;
              io.out_valid <= 1'b1;
              state        <= DONE;
            end else begin
              cnt   <= cnt + CNT_W'(1);
              mul_b <= limb_of(b_q, int'(cnt) + 1);
            end
          end
        end
        DONE: begin
          if (io.out_ready) begin
            io.out_valid <= 1'b0;
            io.in_ready  <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq_ctrl.sv
// Scoreboard bench for booth_mul_seq_ctrl; booth_top is modelled as a plain 256x64 unsigned product.
module tb_booth_mul_seq_ctrl;
  import booth_mul_pkg::*;

`ifdef MUL_PIPE_REG_EN
  localparam int LAT = 2 * N_LIMBS + 1;
  localparam int RPT = 2;
`else
  localparam int LAT = N_LIMBS + 1;
  localparam int RPT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [A_W-1:0]    mul_a;
  logic [LIMB_W-1:0] mul_b;
  logic [P_W-1:0]    mul_p;
  logic              busy;

  booth_mul_seq_ctrl_if io();

  booth_mul_seq_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .io    (io),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_p (mul_p),
    .busy  (busy)
  );

  assign mul_p = P_W'(mul_a) * P_W'(mul_b);

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [RES_W-1:0]  exp_q[$];
  logic [LIMB_W-1:0] obs_b[$];
  int acc_cyc = 0;
  bit seen_v  = 1'b0;

  task automatic check(input string nm, input logic [RES_W-1:0] act, input logic [RES_W-1:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, want);
    end
  endtask

  // Monitor: samples just after the falling edge, once the stimulus has settled.
  always begin
    logic [RES_W-1:0] e;
    @(negedge clk);
    #1;
    if (rst) begin
      seen_v = 1'b0;
    end else begin
      if (io.in_valid && io.in_ready) acc_cyc = cyc;
      if (busy && !io.out_valid) obs_b.push_back(mul_b);
      if (io.out_valid && !seen_v) begin
        seen_v = 1'b1;
        check("latency", RES_W'(cyc - acc_cyc), RES_W'(LAT));
      end
      if (io.out_valid && io.out_ready) begin
        seen_v = 1'b0;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_result: got %h, want no result", io.out_p);
        end else begin
          e = exp_q.pop_front();
          check("out_p", io.out_p, e);
        end
      end
    end
  end

  task automatic issue(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                       input logic [RES_W-1:0] e, input bit push);
    int i;
    i = 0;
    @(negedge clk);
    while (!io.in_ready && i < 100) begin
      @(negedge clk);
      i++;
    end
    check("issue_in_ready", RES_W'(io.in_ready), RES_W'(1));
    io.in_a     = a;
    io.in_b     = b;
    io.in_valid = 1'b1;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    io.in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!io.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("idle_timeout", RES_W'(n < 100), RES_W'(1));
  endtask

  task automatic check_limbs(input string nm, input logic [B_W-1:0] b);
    check({nm, "_count"}, RES_W'(obs_b.size()), RES_W'(N_LIMBS * RPT));
    for (int k = 0; k < N_LIMBS * RPT && k < obs_b.size(); k++)
      check(nm, RES_W'(obs_b[k]), RES_W'(limb_of(b, k / RPT)));
  endtask

  initial begin
    logic [A_W-1:0]   a;
    logic [B_W-1:0]   b;
    logic [RES_W-1:0] e;
    int n;

    rst          = 1'b1;
    io.in_valid  = 1'b0;
    io.in_a      = '0;
    io.in_b      = '0;
    io.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", RES_W'(io.in_ready), RES_W'(1));
    check("rst_out_valid", RES_W'(io.out_valid), RES_W'(0));
    check("rst_busy", RES_W'(busy), RES_W'(0));
    check("rst_out_p", io.out_p, '0);
    check("rst_mul_a", RES_W'(mul_a), '0);
    check("rst_mul_b", RES_W'(mul_b), '0);
    rst = 1'b0;

    // 1 x 1
    obs_b.delete();
    issue(256'd1, 256'd1, 512'd1, 1'b1);
    wait_idle(n);
    check("in_ready_low_cycles", RES_W'(n), RES_W'(LAT));
    check_limbs("mul_b_ones", 256'd1);

    // (2^256-1)^2
    a = '1;
    b = '1;
    e = {{63{4'hF}}, 4'hE, {63{4'h0}}, 4'h1};
    issue(a, b, e, 1'b1);
    wait_idle(n);

    // Limb ordering
    obs_b.delete();
    b = {64'h3, 64'h0, 64'h0, 64'h5};
    e = {256'h0, 64'h3, 128'h0, 64'h5};
    issue(256'd1, b, e, 1'b1);
    wait_idle(n);
    check_limbs("mul_b_order", b);

    // Single-limb B against the reference product
    a = 256'h89375212b2c2846546df998d06b97b0db1f056638484d609c0895e8112153524;
    b = 256'h1e8dcd3d3b23f176;
    e = RES_W'(a) * RES_W'(b);
    issue(a, b, e, 1'b1);
    wait_idle(n);

    // Backpressure: result must hold, new operands ignored
    io.out_ready = 1'b0;
    e = {256'h0, 64'h3, 128'h0, 64'h5};
    issue(256'd1, {64'h3, 64'h0, 64'h0, 64'h5}, e, 1'b1);
    n = 0;
    while (!io.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_timeout", RES_W'(io.out_valid), RES_W'(1));
    for (int k = 0; k < 10; k++) begin
      io.in_valid = k[0];
      io.in_a     = 256'd7;
      io.in_b     = 256'd9;
      @(negedge clk);
      check("bp_out_valid", RES_W'(io.out_valid), RES_W'(1));
      check("bp_out_p", io.out_p, e);
      check("bp_in_ready", RES_W'(io.in_ready), RES_W'(0));
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", RES_W'(io.in_ready), RES_W'(1));
    check("release_out_valid", RES_W'(io.out_valid), RES_W'(0));
    check("release_busy", RES_W'(busy), RES_W'(0));
    check("release_out_p_hold", io.out_p, e);

    // Reset on the second RUN cycle discards the operation
    issue(256'd5, 256'd6, 512'd30, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_rst_in_ready", RES_W'(io.in_ready), RES_W'(1));
    check("midrun_rst_out_valid", RES_W'(io.out_valid), RES_W'(0));
    check("midrun_rst_busy", RES_W'(busy), RES_W'(0));
    check("midrun_rst_out_p", io.out_p, '0);

    a = '1;
    b = '1;
    e = {{63{4'hF}}, 4'hE, {63{4'h0}}, 4'h1};
    issue(a, b, e, 1'b1);
    wait_idle(n);
    check("post_rst_in_ready_low_cycles", RES_W'(n), RES_W'(LAT));

    repeat (5) @(negedge clk);
    check("scoreboard_empty", RES_W'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/booth_mul_seq_ctrl.md
Name: booth_mul_seq_ctrl

Overview:
Sequencer that computes a full 256x256 -> 512-bit unsigned product by time-multiplexing the 256x64 combinational Booth multiplier (booth_top, P = 320 bits) over four 64-bit limbs of B.
- Shift-adds each partial product into a 512-bit accumulator.
- Valid/ready on both sides.
- Sits between the operand source and the shared booth_top instance in the crypto/bignum datapath.
- The attached booth_top is configured for unsigned operands.

Parameters:
A_W, 256, width of operand A and of the multiplier's A port
LIMB_W, 64, width of the multiplier's B port and of one B limb
N_LIMBS, 4, number of B limbs (B width = LIMB_W*N_LIMBS)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  controller can accept operands
in_a  in  256  operand A
in_b  in  256  operand B
mul_a  out  256  to booth_top.A
mul_b  out  64  to booth_top.B
mul_p  in  320  from booth_top.P, combinational
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_p  out  512  product A*B
busy  out  1  high in RUN or DONE

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_p=0, mul_a=0, mul_b=0, limb counter=0, accumulator=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid && in_ready: latch A and B, clear accumulator, cnt=0, go to RUN.
  - RUN: in_ready=0.
    - mul_a = latched A; mul_b = B[LIMB_W*cnt +: LIMB_W], LSB limb first.
    - Each cycle: acc <= acc + (mul_p << (LIMB_W*cnt)), truncated to 512 bits. The exact product fits, so no overflow.
    - cnt increments. On cnt==N_LIMBS-1, go to DONE.
  - DONE: out_valid=1 and out_p=acc, both stable until out_ready. On out_valid && out_ready, go to IDLE next cycle.
- Latency, accept edge to out_valid: N_LIMBS+1 = 5 cycles. Minimum initiation interval: 6 cycles.
- in_ready is 0 in RUN/DONE. in_valid arriving then is ignored (not queued). No combinational path from out_ready to in_ready.
- mul_a and mul_b hold their last values outside RUN.
- out_p holds its final value after out handshake until the next result; out_valid drops.
- rst mid-RUN or in DONE: the next cycle is IDLE with reset values; the in-flight result is discarded.
- Zero operands need no special case; they run the full N_LIMBS cycles.

Optional Feature:
MUL_PIPE_REG_EN
- Defined:
  - mul_p is registered before accumulation, so RUN takes 2 cycles per limb: a drive cycle, then an accumulate cycle.
  - mul_b is held constant across both cycles of a limb.
  - Latency becomes 2*N_LIMBS+1 = 9 cycles. Eases timing through booth_top.
- Undefined: single-cycle-per-limb behaviour as above.
- Results are bit-identical in both builds.

Decomposition:
- Package booth_mul_pkg:
  - constants A_W, LIMB_W, N_LIMBS, P_W=A_W+LIMB_W, RES_W=A_W+LIMB_W*N_LIMBS
  - state enum {IDLE, RUN, DONE}
  - limb-counter width $clog2(N_LIMBS)
- One natural sub-module, booth_mul_acc:
  - 512-bit accumulator with clear and shift-add-at-limb-offset.
  - Keeps the FSM file small.
- booth_top stays outside; it is connected by the parent.

Test Plan:
- A=1, B=1, out_ready=1 -> in_ready drops for 5 cycles. out_valid on cycle 5 with out_p=1. mul_b sequence 1,0,0,0.
- A=B=2^256-1 -> out_p = 2^512-2^257+1, i.e. hex 63×F,E, 63×0,1.
- Limb order: A=1, B={limb3=0x3, limb2=0, limb1=0, limb0=0x5} -> out_p = (3<<192)|5. mul_b observed as 5,0,0,3.
- A=0x89375212b2c2846546df998d06b97b0db1f056638484d609c0895e8112153524, B=0x1e8dcd3d3b23f176 (upper limbs 0) -> out_p equals the 320-bit booth_top product of the same pair, zero-extended to 512 bits.
- Backpressure:
  - out_ready held low 10 cycles after out_valid -> out_valid and out_p stable, in_ready=0, and in_valid pulses are ignored.
  - Release out_ready -> IDLE next cycle.
- rst asserted on RUN cycle 2 -> next cycle in_ready=1, out_valid=0, busy=0. A new operation then completes correctly. Repeat with MUL_PIPE_REG_EN defined: latency 9, same results.
